// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares one single-port memory between the instruction-fetch requester and
// the load/store requester. It issues one access per grant and, for reads,
// counts the fixed memory latency before returning data to the issuing port.
//
// state  | meaning
// -------+---------------------------------------------------------------
// S_IDLE | arbitrating; stores complete in the grant cycle, reads go WAIT
// S_WAIT | read in flight; lat_cnt counts up to MEM_LAT, then rvalid
module mem_port_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 2    // legal range 1..15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } state_t;

  localparam logic [3:0] LAT_LAST = 4'(MEM_LAT);

  state_t     state;
  logic [3:0] lat_cnt;
  logic       owner;   // 0 = fetch, 1 = data
  logic       prio;    // 1 = data wins a tie
  logic       active;  // low while reset is asserted, so no grant can leak out
  logic       gnt_f;
  logic       gnt_d;
  logic       rd_done;

  // Arbitrate only in IDLE; data wins a tie when prio is set, otherwise fetch.
  always_comb begin
    gnt_f = 1'b0;
    gnt_d = 1'b0;
    if (active && (state == S_IDLE)) begin
      gnt_d = d_req && (!if_req || prio);
      gnt_f = if_req && !gnt_d;
    end
  end

  assign rd_done = (state == S_WAIT) && (lat_cnt == LAT_LAST);

  assign if_gnt    = gnt_f;
  assign d_gnt     = gnt_d;
  assign mem_en    = gnt_f | gnt_d;
  assign mem_we    = gnt_d & d_we;
  assign mem_addr  = gnt_d ? d_addr : (gnt_f ? if_addr : '0);
  assign mem_wdata = gnt_d ? d_wdata : '0;

  assign if_rvalid = rd_done & ~owner;
  assign d_rvalid  = rd_done & owner;
  assign if_rdata  = if_rvalid ? mem_rdata : '0;
  assign d_rdata   = d_rvalid ? mem_rdata : '0;

  // Sequencing: grant bookkeeping in IDLE, latency count in WAIT.
  // active clears asynchronously, dropping all grant outputs mid-cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= S_IDLE;
      lat_cnt <= 4'd0;
      owner   <= 1'b0;
      prio    <= 1'b1;
      active  <= 1'b0;
    end else begin
      active <= 1'b1;
      case (state)
        S_IDLE: begin
          if (gnt_f || gnt_d) begin
            // favour the port that did not win this time
            prio <= gnt_f;
            if (gnt_f || !d_we) begin
              state   <= S_WAIT;
              lat_cnt <= 4'd1;
              owner   <= gnt_d;
            end
          end
        end
        S_WAIT: begin
          if (lat_cnt == LAT_LAST) begin
            state   <= S_IDLE;
            lat_cnt <= 4'd0;
          end else begin
            lat_cnt <= lat_cnt + 4'd1;
          end
        end
        default: begin
          state   <= S_IDLE;
          lat_cnt <= 4'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: instance A uses MEM_LAT=2, instance B MEM_LAT=1.
// Stimulus pushes expected grant/return events into a per-instance queue;
// a negedge monitor pops and compares whenever the instance shows activity.
module tb_mem_port_arbiter;

  localparam logic [3:0] K_GIF = 4'b0001;
  localparam logic [3:0] K_GD  = 4'b0010;
  localparam logic [3:0] K_RIF = 4'b0100;
  localparam logic [3:0] K_RD  = 4'b1000;

  typedef struct {
    int          cyc;
    logic [3:0]  kind;
    logic [31:0] addr;
    logic        we;
    logic [31:0] data;
  } evt_t;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;
  evt_t qa[$];
  evt_t qb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // instance A signals
  logic        a_if_req, a_if_gnt, a_if_rvalid, a_d_req, a_d_we, a_d_gnt, a_d_rvalid;
  logic        a_mem_en, a_mem_we;
  logic [31:0] a_if_addr, a_if_rdata, a_d_addr, a_d_wdata, a_d_rdata;
  logic [31:0] a_mem_addr, a_mem_wdata, a_mem_rdata;
  // instance B signals
  logic        b_if_req, b_if_gnt, b_if_rvalid, b_d_req, b_d_we, b_d_gnt, b_d_rvalid;
  logic        b_mem_en, b_mem_we;
  logic [31:0] b_if_addr, b_if_rdata, b_d_addr, b_d_wdata, b_d_rdata;
  logic [31:0] b_mem_addr, b_mem_wdata, b_mem_rdata;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(2)) dut_a (
    .clk(clk), .reset(reset),
    .if_req(a_if_req), .if_addr(a_if_addr), .if_gnt(a_if_gnt),
    .if_rvalid(a_if_rvalid), .if_rdata(a_if_rdata),
    .d_req(a_d_req), .d_we(a_d_we), .d_addr(a_d_addr), .d_wdata(a_d_wdata),
    .d_gnt(a_d_gnt), .d_rvalid(a_d_rvalid), .d_rdata(a_d_rdata),
    .mem_en(a_mem_en), .mem_we(a_mem_we), .mem_addr(a_mem_addr),
    .mem_wdata(a_mem_wdata), .mem_rdata(a_mem_rdata)
  );

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1)) dut_b (
    .clk(clk), .reset(reset),
    .if_req(b_if_req), .if_addr(b_if_addr), .if_gnt(b_if_gnt),
    .if_rvalid(b_if_rvalid), .if_rdata(b_if_rdata),
    .d_req(b_d_req), .d_we(b_d_we), .d_addr(b_d_addr), .d_wdata(b_d_wdata),
    .d_gnt(b_d_gnt), .d_rvalid(b_d_rvalid), .d_rdata(b_d_rdata),
    .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_addr(b_mem_addr),
    .mem_wdata(b_mem_wdata), .mem_rdata(b_mem_rdata)
  );

  // Memory models: read data = address + 3, valid only MEM_LAT cycles after
  // the issue; any other cycle carries junk so leaking rdata is visible.
  int          a_due = -10;
  int          b_due = -10;
  logic [31:0] a_raddr = 32'h0;
  logic [31:0] b_raddr = 32'h0;

  always @(negedge clk) begin
    if (a_mem_en && !a_mem_we) begin a_due = cyc + 2; a_raddr = a_mem_addr; end
    if (b_mem_en && !b_mem_we) begin b_due = cyc + 1; b_raddr = b_mem_addr; end
  end

  always @(posedge clk) begin
    #1;
    a_mem_rdata = (cyc == a_due) ? a_raddr + 32'd3 : (32'hA5A5_0000 ^ 32'(cyc));
    b_mem_rdata = (cyc == b_due) ? b_raddr + 32'd3 : (32'h5A5A_0000 ^ 32'(cyc));
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input int which, input int c, input logic [3:0] k,
                      input logic [31:0] addr, input logic we, input logic [31:0] data);
    evt_t e;
    e.cyc = c; e.kind = k; e.addr = addr; e.we = we; e.data = data;
    if (which == 0) qa.push_back(e);
    else qb.push_back(e);
  endtask

  task automatic mon(input int which, input logic ig, input logic dg, input logic ir,
                     input logic dr, input logic me, input logic mw,
                     input logic [31:0] ma, input logic [31:0] mwd,
                     input logic [31:0] ird, input logic [31:0] drd);
    logic [3:0] k;
    evt_t       e;
    string      p;
    int         qsz;
    p = (which == 0) ? "A" : "B";
    k = {dr, ir, dg, ig};
    chk($sformatf("%s.mem_en_vs_gnt", p), 32'(me), 32'(ig | dg));
    if (!ir) chk($sformatf("%s.if_rdata_idle", p), ird, 32'h0);
    if (!dr) chk($sformatf("%s.d_rdata_idle", p), drd, 32'h0);
    if (!me) chk($sformatf("%s.mem_we_idle", p), 32'(mw), 32'h0);
    if ((k != 4'b0000) || me) begin
      qsz = (which == 0) ? qa.size() : qb.size();
      if (qsz == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL %s.unexpected: got kind %b mem_en %b, required no activity (cycle %0d)",
                 p, k, me, cyc);
      end else begin
        if (which == 0) e = qa.pop_front();
        else e = qb.pop_front();
        chk($sformatf("%s.event_cycle", p), 32'(cyc), 32'(e.cyc));
        chk($sformatf("%s.event_kind", p), 32'(k), 32'(e.kind));
        if (e.kind[1:0] != 2'b00) begin
          chk($sformatf("%s.mem_we", p), 32'(mw), 32'(e.we));
          chk($sformatf("%s.mem_addr", p), ma, e.addr);
          if (e.we) chk($sformatf("%s.mem_wdata", p), mwd, e.data);
        end else begin
          chk($sformatf("%s.rdata", p), e.kind[2] ? ird : drd, e.data);
        end
      end
    end
  endtask

  always @(negedge clk)
    mon(0, a_if_gnt, a_d_gnt, a_if_rvalid, a_d_rvalid, a_mem_en, a_mem_we,
        a_mem_addr, a_mem_wdata, a_if_rdata, a_d_rdata);
  always @(negedge clk)
    mon(1, b_if_gnt, b_d_gnt, b_if_rvalid, b_d_rvalid, b_mem_en, b_mem_we,
        b_mem_addr, b_mem_wdata, b_if_rdata, b_d_rdata);

  task automatic next_cycle();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    next_cycle();
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    reset = 1'b1;
    next_cycle();
    next_cycle();
  endtask

  task automatic chk_a_quiet(input string name);
    chk({name, ".if_gnt"}, 32'(a_if_gnt), 32'h0);
    chk({name, ".d_gnt"}, 32'(a_d_gnt), 32'h0);
    chk({name, ".mem_en"}, 32'(a_mem_en), 32'h0);
    chk({name, ".mem_addr"}, a_mem_addr, 32'h0);
    chk({name, ".if_rvalid"}, 32'(a_if_rvalid), 32'h0);
    chk({name, ".d_rvalid"}, 32'(a_d_rvalid), 32'h0);
  endtask

  int t;

  initial begin
    reset = 1'b0;
    a_if_req = 1'b0; a_if_addr = 32'h0; a_d_req = 1'b0; a_d_we = 1'b0;
    a_d_addr = 32'h0; a_d_wdata = 32'h0;
    b_if_req = 1'b0; b_if_addr = 32'h0; b_d_req = 1'b0; b_d_we = 1'b0;
    b_d_addr = 32'h0; b_d_wdata = 32'h0;

    // reset held with both requests high: nothing may be granted
    a_if_req = 1'b1; a_d_req = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    chk_a_quiet("reset_hold");
    a_if_req = 1'b0; a_d_req = 1'b0;
    next_cycle();
    reset = 1'b1;
    for (int i = 0; i < 10; i++) begin
      next_cycle();
      #1;
      chk("idle.mem_en", 32'(a_mem_en), 32'h0);
    end

    // single fetch, MEM_LAT=2
    next_cycle();
    t = cyc;
    a_if_req = 1'b1; a_if_addr = 32'h0000_0010;
    push(0, t,     K_GIF, 32'h10, 1'b0, 32'h0);
    push(0, t + 2, K_RIF, 32'h0,  1'b0, 32'h13);
    next_cycle();
    a_if_req = 1'b0; a_if_addr = 32'h0;
    repeat (3) next_cycle();

    // contention right after reset: data first, then fetch
    do_reset();
    t = cyc;
    a_if_req = 1'b1; a_if_addr = 32'h0;
    a_d_req = 1'b1; a_d_we = 1'b0; a_d_addr = 32'h100;
    push(0, t,     K_GD,  32'h100, 1'b0, 32'h0);
    push(0, t + 2, K_RD,  32'h0,   1'b0, 32'h103);
    push(0, t + 3, K_GIF, 32'h0,   1'b0, 32'h0);
    push(0, t + 5, K_RIF, 32'h0,   1'b0, 32'h3);
    next_cycle();
    a_d_req = 1'b0;
    repeat (3) next_cycle();
    a_if_req = 1'b0;
    repeat (2) next_cycle();

    // back-to-back stores
    do_reset();
    t = cyc;
    a_d_req = 1'b1; a_d_we = 1'b1; a_d_addr = 32'h200; a_d_wdata = 32'hDEAD_BEEF;
    push(0, t, K_GD, 32'h200, 1'b1, 32'hDEAD_BEEF);
    next_cycle();
    a_d_addr = 32'h204; a_d_wdata = 32'hCAFE_F00D;
    push(0, t + 1, K_GD, 32'h204, 1'b1, 32'hCAFE_F00D);
    next_cycle();
    a_d_req = 1'b0; a_d_we = 1'b0; a_d_addr = 32'h0; a_d_wdata = 32'h0;
    repeat (3) next_cycle();

    // reset during an in-flight fetch: read abandoned, prio back to data
    do_reset();
    t = cyc;
    a_if_req = 1'b1; a_if_addr = 32'h40;
    push(0, t, K_GIF, 32'h40, 1'b0, 32'h0);
    next_cycle();
    a_if_req = 1'b0;
    reset = 1'b0;
    #1;
    chk_a_quiet("reset_mid_read");
    next_cycle();
    next_cycle();
    reset = 1'b1;
    next_cycle();
    a_if_req = 1'b1; a_if_addr = 32'h44;
    a_d_req = 1'b1; a_d_we = 1'b0; a_d_addr = 32'h300;
    push(0, t + 4, K_GD,  32'h300, 1'b0, 32'h0);
    push(0, t + 6, K_RD,  32'h0,   1'b0, 32'h303);
    push(0, t + 7, K_GIF, 32'h44,  1'b0, 32'h0);
    push(0, t + 9, K_RIF, 32'h0,   1'b0, 32'h47);
    next_cycle();
    a_d_req = 1'b0;
    repeat (3) next_cycle();
    a_if_req = 1'b0;
    repeat (3) next_cycle();

    // MEM_LAT=1: back-to-back fetches with if_req held
    next_cycle();
    t = cyc;
    b_if_req = 1'b1; b_if_addr = 32'h1000;
    push(1, t,     K_GIF, 32'h1000, 1'b0, 32'h0);
    push(1, t + 1, K_RIF, 32'h0,    1'b0, 32'h1003);
    next_cycle();
    b_if_addr = 32'h1004;
    push(1, t + 2, K_GIF, 32'h1004, 1'b0, 32'h0);
    push(1, t + 3, K_RIF, 32'h0,    1'b0, 32'h1007);
    next_cycle();
    next_cycle();
    b_if_addr = 32'h1008;
    push(1, t + 4, K_GIF, 32'h1008, 1'b0, 32'h0);
    push(1, t + 5, K_RIF, 32'h0,    1'b0, 32'h100B);
    next_cycle();
    next_cycle();
    b_if_req = 1'b0;
    repeat (3) next_cycle();

    chk("A.pending_events", 32'(qa.size()), 32'h0);
    chk("B.pending_events", 32'(qb.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port unified memory between the core's instruction-fetch requester and its load/store requester.
- Grants one transaction at a time using req/gnt handshakes.
- Counts the fixed memory read latency and returns read data to the requester that issued the read.
- Sits between pc/fetch logic, the load/store path, and the shared memory macro. This is the step toward multi-cycle, stall-aware fetch/data access.

Parameters:
ADDR_W, 32, address width of both requesters and the memory
DATA_W, 32, data width
MEM_LAT, 2, cycles from a read issue (mem_en=1, mem_we=0) to mem_rdata valid; legal range 1..15

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset (0 = reset asserted)
if_req  in  1  fetch read request; held with if_addr stable until if_gnt
if_addr  in  ADDR_W  fetch address
if_gnt  out  1  fetch request accepted/issued this cycle
if_rvalid  out  1  one-cycle pulse: if_rdata valid
if_rdata  out  DATA_W  fetch read data
d_req  in  1  data request; held with d_we/d_addr/d_wdata stable until d_gnt
d_we  in  1  1 = store, 0 = load
d_addr  in  ADDR_W  data address
d_wdata  in  DATA_W  store data
d_gnt  out  1  data request accepted/issued this cycle
d_rvalid  out  1  one-cycle pulse: d_rdata valid (loads only)
d_rdata  out  DATA_W  load data
mem_en  out  1  memory access strobe
mem_we  out  1  memory write enable
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_rdata  in  DATA_W  memory read data, valid MEM_LAT cycles after the read issue

Behaviour:
- State machine: IDLE, WAIT.
- Registered state: state, lat_cnt (4 bits), owner (0=fetch, 1=data), prio (1 = data wins tie).
- Reset (reset=0, asynchronous): state=IDLE, lat_cnt=0, owner=0, prio=1.
  - All outputs then read 0: gnt, rvalid, mem_en, mem_we; mem_addr, mem_wdata, rdata = 0.
  - An in-flight read is abandoned: no rvalid is ever produced for it.
- Issuing a request (IDLE only):
  - Grant logic is combinational from state, the req inputs and prio. Exactly one gnt is asserted in the same cycle as mem_en.
  - Only fetch requesting: grant fetch. Only data requesting: grant data. Both requesting: grant data if prio=1, else fetch.
  - On any grant, prio toggles to favour the loser: prio <= (granted==fetch). This gives round-robin under contention.
  - mem_addr/mem_wdata/mem_we come from the granted port. mem_we=0 for fetch.
- Store grant (d_we=1): mem_we=1 for that cycle; state stays IDLE; no d_rvalid. Back-to-back grants are possible every cycle.
- Read grant (fetch, or data with d_we=0): state<=WAIT, lat_cnt<=1, owner<=granted port.
- WAIT:
  - No gnt; mem_en=0.
  - lat_cnt increments each cycle.
  - In the cycle where lat_cnt==MEM_LAT, the owner's rvalid=1 and its rdata=mem_rdata (combinational pass-through). Next cycle state=IDLE.
- Result: read issue-to-rvalid latency = MEM_LAT cycles. The next grant is no earlier than the cycle after rvalid, so peak read throughput is one read per MEM_LAT+1 cycles.
- rdata outputs are 0 whenever their rvalid=0.
- Requests arriving during WAIT are not granted. They must be held (requirement on requesters) and are arbitrated on return to IDLE.
- A requester dropping req before gnt is legal; nothing is issued for it.
- if_rvalid and d_rvalid are never both 1. if_gnt and d_gnt are never both 1.
- Address and data pass through unmodified; no alignment checks.

Test Plan:
- Reset then idle, MEM_LAT=2: both req=0 -> all outputs 0, state IDLE, no mem_en for 10 cycles.
- Single fetch, if_addr=0x0000_0010:
  - if_gnt and mem_en in cycle T with mem_addr=0x10, mem_we=0.
  - mem_rdata=0x0000_0013 at T+2 -> if_rvalid=1, if_rdata=0x13 at T+2 only.
- Contention after reset, both req held, d_we=0, d_addr=0x100, if_addr=0x0:
  - Data granted first at T; d_rvalid at T+2.
  - Fetch granted at T+3; if_rvalid at T+5.
- Stores: d_req=1, d_we=1 with d_addr=0x200/wdata=0xDEAD_BEEF, then 0x204/0xCAFE_F00D, no fetch requests -> d_gnt, mem_en and mem_we each high on two consecutive cycles with matching addr/data; d_rvalid stays 0.
- Reset mid-read: fetch granted at T; reset=0 at T+1 (async, mid-cycle) -> outputs 0 immediately. After release, no if_rvalid appears, and a new d_req is granted (prio=1).
- MEM_LAT=1 back-to-back fetches, if_req held:
  - Grants at T, T+2, T+4.
  - rvalid at T+1, T+3, T+5.
  - Read data matches mem_rdata in each of those cycles.
